wave_capture: RTL and testbench

//  Writer side of the wave_display sample RAM (ping-pong double buffer).

---
 rtl/wave_capture.sv | 121 ++++++++++++
 tb/tb_wave_capture.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Writer side of the ping-pong sample RAM. Arms on a rising zero crossing, or on a
// forced trigger after a timeout, then fills the half that the display is not reading.
module wave_capture #(
  parameter int ADDR_W    = 8,
  parameter int AUTO_TRIG = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_sample_ready,
  input  logic [15:0]       new_sample_in,
  input  logic              wave_display_idle,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        write_sample,
  output logic              read_index,
  output logic              capturing
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int CNT_W = (AUTO_TRIG > 1) ? $clog2(AUTO_TRIG) : 1;
  localparam logic [CNT_W-1:0] ARM_LAST = (AUTO_TRIG > 0) ? CNT_W'(AUTO_TRIG - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  index, index_n, wr_idx;
  logic [CNT_W-1:0]  arm_cnt, arm_cnt_n;
  logic              read_index_n;
  logic              prev_neg;
  logic              accept;
  logic              crossing, forced, trig;
  logic              we_n, cap_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        data_n;

  assign crossing = new_sample_ready && prev_neg && !new_sample_in[15];
  assign forced   = (AUTO_TRIG != 0) && new_sample_ready && (arm_cnt == ARM_LAST);
  assign trig     = crossing || forced;

  // State register; prev_neg tracks the sign of every strobed sample regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_ARMED;
      index         <= '0;
      arm_cnt       <= '0;
      read_index    <= 1'b0;
      prev_neg      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      capturing     <= 1'b0;
    end else begin
      state         <= state_n;
      index         <= index_n;
      arm_cnt       <= arm_cnt_n;
      read_index    <= read_index_n;
      write_enable  <= we_n;
      write_address <= addr_n;
      write_sample  <= data_n;
      capturing     <= cap_n;
      if (new_sample_ready) prev_neg <= new_sample_in[15];
    end
  end

  // Next-state logic
  always_comb begin
    state_n      = state;
    index_n      = index;
    arm_cnt_n    = arm_cnt;
    read_index_n = read_index;
    accept       = 1'b0;
    wr_idx       = index;
    case (state)
      S_ARMED: begin
        wr_idx = '0;
        if (trig) begin
          accept    = 1'b1;
          index_n   = IDX_W'(1);
          arm_cnt_n = '0;
          state_n   = S_ACTIVE;
        end else if (new_sample_ready) begin
          arm_cnt_n = arm_cnt + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (new_sample_ready) begin
          accept = 1'b1;
          if (index == IDX_LAST) begin
            index_n = '0;
            state_n = S_WAIT;
          end else begin
            index_n = index + 1'b1;
          end
        end
      end
      S_WAIT: begin
        // The flip is the only place read_index moves, so the read half is never written.
        if (wave_display_idle) begin
          read_index_n = ~read_index;
          arm_cnt_n    = '0;
          state_n      = S_ARMED;
        end
      end
      default: state_n = S_ARMED;
    endcase
  end

  // Output logic: registered RAM write port, address/data hold between writes
  always_comb begin
    we_n   = accept;
    addr_n = write_address;
    data_n = write_sample;
    if (accept) begin
      addr_n = {~read_index, wr_idx};
      data_n = new_sample_in[15:8] ^ 8'h80;
    end
    cap_n = (state_n == S_ACTIVE);
  end

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: vector table for short sequences plus
// hand-written loops for full captures, timeout trigger and mid-capture reset.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;
  logic        write_enable;
  logic [7:0]  write_address;
  logic [7:0]  write_sample;
  logic        read_index;
  logic        capturing;

  int n_cmp = 0;
  int n_err = 0;

  wave_capture #(.ADDR_W(8), .AUTO_TRIG(512)) dut (
    .clk              (clk),
    .rst              (rst),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .wave_display_idle(wave_display_idle),
    .write_enable     (write_enable),
    .write_address    (write_address),
    .write_sample     (write_sample),
    .read_index       (read_index),
    .capturing        (capturing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        rdy;
    logic [15:0] s;
    logic        idl;
    logic        we;
    logic        wd;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        ri;
    logic        cap;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs held across the edge, outputs sampled 1ns later, strobes cleared.
  task automatic step(input logic r, input logic rdy, input logic [15:0] s, input logic idl);
    rst = r; new_sample_ready = rdy; new_sample_in = s; wave_display_idle = idl;
    @(posedge clk); #1;
    rst = 1'b0; new_sample_ready = 1'b0; wave_display_idle = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tv[i].r, tv[i].rdy, tv[i].s, tv[i].idl);
      chk($sformatf("v%0d_we", i), 32'(write_enable), 32'(tv[i].we));
      chk($sformatf("v%0d_ri", i), 32'(read_index), 32'(tv[i].ri));
      chk($sformatf("v%0d_cap", i), 32'(capturing), 32'(tv[i].cap));
      if (tv[i].wd) begin
        chk($sformatf("v%0d_addr", i), 32'(write_address), 32'(tv[i].addr));
        chk($sformatf("v%0d_data", i), 32'(write_sample), 32'(tv[i].data));
      end
    end
  endtask

  // Back-to-back strobes for buffer slots from..to; high byte ~idx (all negative).
  task automatic run_capture(input int from, input int to, input logic ri_exp, input string tag);
    for (int idx = from; idx <= to; idx++) begin
      logic [7:0] hb;
      logic [7:0] ia;
      ia = 8'(idx);
      hb = ~ia;
      step(1'b0, 1'b1, {hb, 8'h33}, 1'b0);
      chk($sformatf("%s_we%0d", tag, idx), 32'(write_enable), 32'd1);
      chk($sformatf("%s_addr%0d", tag, idx), 32'(write_address), 32'({~ri_exp, ia[6:0]}));
      chk($sformatf("%s_data%0d", tag, idx), 32'(write_sample), 32'(hb ^ 8'h80));
      chk($sformatf("%s_cap%0d", tag, idx), 32'(capturing), 32'(idx != 127));
    end
  endtask

  initial begin
    int writes;
    //           r     rdy   s         idl   we    wd    addr   data   ri    cap
    tv[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1};
    tv[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    // WAIT: idle together with a crossing strobe flips but does not trigger
    tv[4] = '{1'b0, 1'b1, 16'h0700, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b1, 16'h0900, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b1, 16'h1200, 1'b0, 1'b1, 1'b1, 8'h00, 8'h92, 1'b1, 1'b1};
    tv[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};

    // Reset values, then -5,+3 crossing writes slot 0 of the upper half
    run_vecs(0, 3);

    // Rest of the first capture, then a strobe in WAIT must not write
    run_capture(1, 127, 1'b0, "cap1");
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    chk("wait_no_we", 32'(write_enable), 32'd0);
    chk("wait_cap", 32'(capturing), 32'd0);
    chk("wait_ri", 32'(read_index), 32'd0);

    // Display idle flips the read half; next capture lands in the lower half
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("flip_ri", 32'(read_index), 32'd1);
    step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    chk("cap2_neg_we", 32'(write_enable), 32'd0);
    step(1'b0, 1'b1, 16'h0001, 1'b0);
    chk("cap2_we0", 32'(write_enable), 32'd1);
    chk("cap2_addr0", 32'(write_address), 32'h00);
    chk("cap2_data0", 32'(write_sample), 32'h80);
    run_capture(1, 127, 1'b1, "cap2");
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("flip_back_ri", 32'(read_index), 32'd0);

    // Timeout trigger: constant +100, strobes 1..511 write nothing, 512 writes
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    writes = 0;
    for (int k = 1; k <= 511; k++) begin
      step(1'b0, 1'b1, 16'd100, 1'b0);
      if (write_enable || capturing) writes++;
    end
    chk("auto_quiet_511", 32'(writes), 32'd0);
    step(1'b0, 1'b1, 16'd100, 1'b0);
    chk("auto_we", 32'(write_enable), 32'd1);
    chk("auto_addr", 32'(write_address), 32'h80);
    chk("auto_data", 32'(write_sample), 32'h80);
    chk("auto_cap", 32'(capturing), 32'd1);
    run_capture(1, 127, 1'b0, "cap3");
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("flip3_ri", 32'(read_index), 32'd1);

    // Mid-capture reset at index 40 with read_index=1
    step(1'b0, 1'b1, 16'h0400, 1'b0);
    chk("cap4_we0", 32'(write_enable), 32'd1);
    chk("cap4_addr0", 32'(write_address), 32'h00);
    run_capture(1, 39, 1'b1, "cap4");
    step(1'b1, 1'b1, 16'h0500, 1'b0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_cap", 32'(capturing), 32'd0);
    chk("rst_ri", 32'(read_index), 32'd0);
    step(1'b0, 1'b1, 16'h0500, 1'b0);
    chk("rst_no_trig", 32'(write_enable), 32'd0);
    step(1'b0, 1'b1, 16'hFB00, 1'b0);
    chk("rst_neg", 32'(write_enable), 32'd0);
    step(1'b0, 1'b1, 16'h0500, 1'b0);
    chk("rst_recap_we", 32'(write_enable), 32'd1);
    chk("rst_recap_addr", 32'(write_address), 32'h80);
    chk("rst_recap_data", 32'(write_sample), 32'h85);
    chk("rst_recap_cap", 32'(capturing), 32'd1);

    // Fill to WAIT (last sample negative), then idle + crossing in the same cycle
    run_capture(1, 127, 1'b0, "cap5");
    run_vecs(4, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
